// File: rtl/fec_serdes_pkg.sv
// Shared definitions for the FEC serializer/deserializer pair: state encoding,
// index-width helpers and the clamp used when latching frame geometry.
package fec_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DRAIN   = 2'd2
  } deser_state_t;

  function automatic int unsigned width_idx_bits(input int unsigned data_width);
    return $clog2(data_width) + 32'd1;
  endfunction

  function automatic int unsigned depth_idx_bits(input int unsigned data_depth);
    return $clog2(data_depth) + 32'd1;
  endfunction

  function automatic logic [31:0] clamp_hi(input logic [31:0] value, input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  function automatic logic [31:0] clamp_lo(input logic [31:0] value, input logic [31:0] limit);
    return (value < limit) ? limit : value;
  endfunction

endpackage

// File: rtl/deser_core_if.sv
// Serial input and parallel output bundle of the deserializer. The master
// side drives the serial stream and frame geometry; the slave is deser_core.
interface deser_core_if
  import fec_serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
);
  localparam int WW = width_idx_bits(DATA_WIDTH);
  localparam int SW = depth_idx_bits(DATA_DEPTH);

  logic                                 serial_in;
  logic                                 serial_en;
  logic [DIV_WIDTH-1:0]                 clk_div;
  logic [WW-1:0]                        width;
  logic [SW-1:0]                        depth;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out;
  logic                                 valid;
  logic                                 err;
  logic                                 busy;
  logic [WW-1:0]                        bit_count;
  logic [SW-1:0]                        sample_count;

  modport master (
    output serial_in, serial_en, clk_div, width, depth,
    input  par_out, valid, err, busy, bit_count, sample_count
  );

  modport slave (
    input  serial_in, serial_en, clk_div, width, depth,
    output par_out, valid, err, busy, bit_count, sample_count
  );

endinterface

// File: rtl/deser_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and raises the
// mid-bit sample strobe and end-of-bit advance strobe.
module deser_bit_timer
  import fec_serdes_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 sample_stb,
  output logic                 adv_stb
);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1'b1);

  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] clk_cnt;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] cnt_eff;
  logic [DIV_WIDTH-1:0] last_cnt;
  logic                 counting;

  // The start cycle is already bit-cycle 0, so it uses the live divider and a zero count.
  always_comb begin
    counting   = start | run;
    div_eff    = start ? DIV_WIDTH'(clamp_lo(32'(clk_div), 32'd1)) : div_r;
    cnt_eff    = start ? '0 : clk_cnt;
    last_cnt   = div_eff - ONE;
    sample_stb = counting && (cnt_eff == (last_cnt >> 1'b1));
    adv_stb    = counting && (cnt_eff == last_cnt);
  end

  // Divider latch and in-bit cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r   <= ONE;
      clk_cnt <= '0;
    end else begin
      if (start) begin
        div_r <= div_eff;
      end
      if (counting) begin
        clk_cnt <= adv_stb ? '0 : cnt_eff + ONE;
      end else begin
        clk_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/deser_core.sv
// Serial-to-parallel frame receiver: reassembles LSB-first words into a
// DATA_DEPTH x DATA_WIDTH frame, pulsing valid per frame and err on abort.
module deser_core
  import fec_serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic         clk,
  input  logic         rst,
  deser_core_if.slave  bus
);
  localparam int WW = width_idx_bits(DATA_WIDTH);
  localparam int SW = depth_idx_bits(DATA_DEPTH);
  localparam int BI = $clog2(DATA_WIDTH);
  localparam int SI = $clog2(DATA_DEPTH);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RECEIVE = RECEIVE;
  localparam logic [1:0] S_DRAIN   = DRAIN;

  logic [1:0]                            state;
  logic [WW-1:0]                         width_r;
  logic [SW-1:0]                         depth_r;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow_nxt;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out_r;
  logic                                  valid_r;
  logic                                  err_r;
  logic                                  busy_r;
  logic [WW-1:0]                         bit_count;
  logic [SW-1:0]                         sample_count;

  logic          start;
  logic          run;
  logic          rx_active;
  logic          sample_stb;
  logic          adv_stb;
  logic [WW-1:0] w_eff;
  logic [SW-1:0] d_eff;
  logic          word_done;
  logic          frame_done;

  deser_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .clk_div    (bus.clk_div),
    .sample_stb (sample_stb),
    .adv_stb    (adv_stb)
  );

  // Frame geometry comes straight from the ports in the start cycle, from the latches after.
  always_comb begin
    start      = (state == S_IDLE) && bus.serial_en;
    run        = (state == S_RECEIVE) && bus.serial_en;
    rx_active  = start | run;
    w_eff      = start ? WW'(clamp_hi(32'(bus.width), 32'(DATA_WIDTH - 1))) : width_r;
    d_eff      = start ? SW'(clamp_hi(32'(bus.depth), 32'(DATA_DEPTH - 1))) : depth_r;
    word_done  = (bit_count == w_eff);
    frame_done = word_done && (sample_count == d_eff);
  end

  // Shadow frame with the current sample merged in; cleared at frame start.
  always_comb begin
    shadow_nxt = start ? '0 : shadow;
    if (sample_stb) begin
      shadow_nxt[sample_count[SI-1:0]][bit_count[BI-1:0]] = bus.serial_in;
    end else begin
      shadow_nxt = shadow_nxt;
    end
  end

  // Receive FSM, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      width_r      <= '0;
      depth_r      <= '0;
      shadow       <= '0;
      par_out_r    <= '0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      bit_count    <= '0;
      sample_count <= '0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        S_IDLE, S_RECEIVE: begin
          if (rx_active) begin
            shadow <= shadow_nxt;
            if (start) begin
              width_r <= w_eff;
              depth_r <= d_eff;
            end
            if (adv_stb && frame_done) begin
              par_out_r    <= shadow_nxt;
              valid_r      <= 1'b1;
              state        <= S_DRAIN;
              busy_r       <= 1'b0;
              bit_count    <= '0;
              sample_count <= '0;
            end else begin
              state  <= S_RECEIVE;
              busy_r <= 1'b1;
              if (adv_stb && word_done) begin
                bit_count    <= '0;
                sample_count <= sample_count + SW'(1'b1);
              end else if (adv_stb) begin
                bit_count <= bit_count + WW'(1'b1);
              end
            end
          end else begin
            // Reaching here in RECEIVE means serial_en dropped mid-frame.
            err_r        <= (state == S_RECEIVE);
            state        <= S_IDLE;
            busy_r       <= 1'b0;
            bit_count    <= '0;
            sample_count <= '0;
          end
        end
        S_DRAIN: begin
          busy_r <= 1'b0;
          if (!bus.serial_en) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          busy_r       <= 1'b0;
          bit_count    <= '0;
          sample_count <= '0;
        end
      endcase
    end
  end

  assign bus.par_out      = par_out_r;
  assign bus.valid        = valid_r;
  assign bus.err          = err_r;
  assign bus.busy         = busy_r;
  assign bus.bit_count    = bit_count;
  assign bus.sample_count = sample_count;

endmodule

// File: tb/tb_deser_core.sv
// Directed bench for deser_core: table of frames with hand-computed results,
// plus abort and mid-frame reset sequences.
module tb_deser_core;
  import fec_serdes_pkg::*;

  typedef struct {
    logic [7:0]       div;
    logic [5:0]       w;
    logic [2:0]       d;
    logic [3:0][31:0] words;
    int               drain;
    logic [3:0][31:0] exp;
    int               lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deser_core_if #(.DATA_WIDTH(32), .DATA_DEPTH(4), .DIV_WIDTH(8)) bus();

  deser_core #(.DATA_WIDTH(32), .DATA_DEPTH(4), .DIV_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int edge_cnt = 0;
  int valid_total = 0;
  int err_total = 0;
  int valid_edge = -1;
  int err_edge = -1;
  int tests = 0;
  int fails = 0;
  vec_t vecs[7];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_total = valid_total + 1;
      valid_edge  = edge_cnt;
    end
    if (bus.err === 1'b1) begin
      err_total = err_total + 1;
      err_edge  = edge_cnt;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transmit one frame; abort_bits >= 0 drops serial_en after that many bits.
  task automatic send_frame(input logic [7:0] div, input logic [5:0] w, input logic [2:0] d,
                            input logic [3:0][31:0] words, input int drain, input int abort_bits,
                            output int start_edge);
    int eff_div, eff_w, eff_d, sent;
    eff_div = (div == 8'd0) ? 1 : int'(div);
    eff_w   = (w > 6'd31) ? 31 : int'(w);
    eff_d   = (d > 3'd3) ? 3 : int'(d);
    @(posedge clk); #1;
    bus.clk_div   = div;
    bus.width     = w;
    bus.depth     = d;
    bus.serial_en = 1'b1;
    start_edge    = edge_cnt;
    sent          = 0;
    for (int wi = 0; wi <= eff_d; wi++) begin
      for (int bi = 0; bi <= eff_w; bi++) begin
        if (sent != abort_bits) begin
          bus.serial_in = words[wi][bi];
          for (int c = 0; c < eff_div; c++) begin
            @(posedge clk); #1;
            bus.clk_div = 8'($urandom);
            bus.width   = 6'($urandom);
            bus.depth   = 3'($urandom);
          end
          sent = sent + 1;
        end
      end
    end
    if (abort_bits < 0) begin
      for (int k = 0; k < drain; k++) begin
        bus.serial_in = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.serial_en = 1'b0;
    bus.serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s, v0, e0;
    v0 = valid_total;
    e0 = err_total;
    send_frame(v.div, v.w, v.d, v.words, v.drain, -1, s);
    check({tag, " valid_count"}, 128'(valid_total - v0), 128'd1);
    check({tag, " err_count"}, 128'(err_total - e0), 128'd0);
    check({tag, " valid_latency"}, 128'(valid_edge - s), 128'(v.lat));
    check({tag, " par_out"}, bus.par_out, v.exp);
  endtask

  initial begin
    int s, v0, e0;
    rst           = 1'b1;
    bus.serial_in = 1'b0;
    bus.serial_en = 1'b0;
    bus.clk_div   = 8'd0;
    bus.width     = 6'd0;
    bus.depth     = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst par_out", bus.par_out, 128'd0);
    check("rst valid", 128'(bus.valid), 128'd0);
    check("rst err", 128'(bus.err), 128'd0);
    check("rst busy", 128'(bus.busy), 128'd0);
    check("rst bit_count", 128'(bus.bit_count), 128'd0);
    check("rst sample_count", 128'(bus.sample_count), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{8'd4, 6'd31, 3'd3,
                {32'h0000FFFF, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF}, 0,
                {32'h0000FFFF, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF}, 512};
    vecs[1] = '{8'd0, 6'd7, 3'd0,
                {32'h0, 32'h0, 32'h0, 32'hFFFFFFA5}, 0,
                {32'h0, 32'h0, 32'h0, 32'h000000A5}, 8};
    vecs[2] = '{8'd1, 6'd7, 3'd0,
                {32'h0, 32'h0, 32'h0, 32'hFFFFFFA5}, 0,
                {32'h0, 32'h0, 32'h0, 32'h000000A5}, 8};
    vecs[3] = '{8'd2, 6'd40, 3'd7,
                {32'h0F0F0F0F, 32'h13579BDF, 32'h2468ACE0, 32'hCAFEF00D}, 0,
                {32'h0F0F0F0F, 32'h13579BDF, 32'h2468ACE0, 32'hCAFEF00D}, 256};
    vecs[4] = '{8'd3, 6'd15, 3'd1,
                {32'h0, 32'h0, 32'h80017E81, 32'hFFFFC3A5}, 5,
                {32'h0, 32'h0, 32'h00007E81, 32'h0000C3A5}, 96};
    vecs[5] = '{8'd1, 6'd0, 3'd0,
                {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001}, 2,
                {32'h0, 32'h0, 32'h0, 32'h00000001}, 1};
    vecs[6] = '{8'd5, 6'd4, 3'd2,
                {32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFFEA, 32'hFFFFFFF5}, 0,
                {32'h0, 32'h0000001F, 32'h0000000A, 32'h00000015}, 75};

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort after 10 bits; previous frame must survive.
    run_vec(vecs[0], "pre_abort");
    v0 = valid_total;
    e0 = err_total;
    send_frame(8'd3, 6'd31, 3'd3, vecs[3].words, 0, 10, s);
    check("abort err_count", 128'(err_total - e0), 128'd1);
    check("abort valid_count", 128'(valid_total - v0), 128'd0);
    check("abort err_edge", 128'(err_edge - s), 128'd31);
    check("abort par_out", bus.par_out, vecs[0].exp);
    check("abort busy", 128'(bus.busy), 128'd0);
    run_vec(vecs[4], "post_abort");

    // Reset during word 2 of a divide-by-2 frame.
    v0 = valid_total;
    e0 = err_total;
    @(posedge clk); #1;
    bus.clk_div   = 8'd2;
    bus.width     = 6'd31;
    bus.depth     = 3'd3;
    bus.serial_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      bus.serial_in = vecs[0].words[k / 32][k % 32];
      repeat (2) @(posedge clk);
      #1;
    end
    check("mid busy", 128'(bus.busy), 128'd1);
    check("mid bit_count", 128'(bus.bit_count), 128'd6);
    check("mid sample_count", 128'(bus.sample_count), 128'd2);
    rst = 1'b1;
    #1;
    check("mrst par_out", bus.par_out, 128'd0);
    check("mrst valid", 128'(bus.valid), 128'd0);
    check("mrst busy", 128'(bus.busy), 128'd0);
    check("mrst bit_count", 128'(bus.bit_count), 128'd0);
    check("mrst sample_count", 128'(bus.sample_count), 128'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.serial_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst err_count", 128'(err_total - e0), 128'd0);
    check("mrst valid_count", 128'(valid_total - v0), 128'd0);
    run_vec(vecs[3], "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deser_core.md
# deser_core

Serial-to-parallel receiver for the FEC datapath, directly downstream of the serializer. It consumes a bit stream from `serial_in`, qualified by `serial_en`, in which each bit is held for `clk_div` clock cycles. Bits arrive LSB first within a word, and word 0 comes first. The block reassembles them into a `DATA_DEPTH` x `DATA_WIDTH` packed array and pulses `valid` once per completed frame. It uses the same width and depth encoding as the serializer, so the two blocks can be connected directly in loopback.

## Interface
Parameters:
- `DATA_WIDTH`, 32: maximum bits per word.
- `DATA_DEPTH`, 4: maximum words per frame.
- `DIV_WIDTH`, 8: width of `clk_div`.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `serial_in`, input, 1: serial data.
- `serial_en`, input, 1: high while the transmitter is sending.
- `clk_div`, input, `DIV_WIDTH`: clock cycles per bit. A value of 0 is treated as 1.
- `width`, input, `$clog2(DATA_WIDTH)+1`: index of the last bit in a word. Bits per word = `width`+1.
- `depth`, input, `$clog2(DATA_DEPTH)+1`: index of the last word. Words per frame = `depth`+1.
- `par_out`, output, `[DATA_DEPTH-1:0][DATA_WIDTH-1:0]`: last complete frame. Held until the next `valid`.
- `valid`, output, 1: one-cycle pulse that marks `par_out` as updated.
- `err`, output, 1: one-cycle pulse when a frame is aborted.
- `busy`, output, 1: high while a frame is in progress.
- `bit_count`, output, `$clog2(DATA_WIDTH)+1`: current bit index.
- `sample_count`, output, `$clog2(DATA_DEPTH)+1`: current word index.

## Operation
- States are `IDLE`, `RECEIVE` and `DRAIN`.
- **IDLE.** The cycle in which `serial_en` is first seen high is bit-cycle 0 of bit 0. In that cycle the block:
  - latches `clk_div`, `width` and `depth`;
  - clamps the latched values: `width_r` = min(`width`, `DATA_WIDTH`-1), `depth_r` = min(`depth`, `DATA_DEPTH`-1), `div_r` = max(`clk_div`, 1);
  - clears the shadow frame register;
  - enters `RECEIVE`.
  
  This cycle is processed with the same sampling and advance rules as `RECEIVE`.
- **RECEIVE.**
  - `clk_cnt` counts 0 to `div_r`-1.
  - Sample strobe: when `clk_cnt` == (`div_r`-1)>>1, write `serial_in` into `shadow[sample_count][bit_count]`.
  - Advance strobe: when `clk_cnt` == `div_r`-1, set `clk_cnt` to 0 and increment `bit_count`. When `bit_count` == `width_r`, wrap `bit_count` to 0 and increment `sample_count`.
  - On the advance strobe of bit (`width_r`, `depth_r`): copy `shadow` to `par_out`, pulse `valid`, and go to `DRAIN`.
- **Abort.** If `serial_en` is 0 in any `RECEIVE` cycle (the first cycle excluded), pulse `err` and go to `IDLE`. `par_out` is unchanged and `valid` stays 0.
- **DRAIN.** Wait for `serial_en` to be 0, then go to `IDLE`. Data arriving during `DRAIN` is ignored. This absorbs the transmitter's trailing `serial_en` cycles.
- **Unused bits.** Bits of `par_out` above `width_r` and words above `depth_r` read 0.
- **Outputs.**
  - `busy` = (state == `RECEIVE`).
  - `bit_count` and `sample_count` are cleared in `IDLE`.
- **Reset.** `rst` asserted at any time forces `IDLE`. `par_out`, `valid`, `err`, `busy`, `bit_count`, `sample_count`, `clk_cnt` and `shadow` all go to 0. A frame in progress is discarded and no `err` pulse is produced.

## Timing
- All outputs are registered.
- If `serial_en` is first high at cycle T, `valid` is high at cycle T + N·`div_r`, where N = (`width_r`+1)(`depth_r`+1).
- `par_out` updates on the same edge that raises `valid`.
- `err` rises one cycle after the first low `serial_en` sampled in `RECEIVE`.
- With `div_r` = 1, the sample and advance strobes fire in the same cycle and one bit is taken per cycle.
- A new frame can start in the cycle after `serial_en` is seen low in `DRAIN`, or after an abort.
- `clk_div`, `width` and `depth` are ignored outside the latch cycle.

## Structure
- Package `fec_serdes_pkg`, shared with the serializer, holds:
  - `deser_state_t` {`IDLE`, `RECEIVE`, `DRAIN`};
  - the width/depth index width helper functions;
  - the clamp function.
- Sub-module `deser_bit_timer` owns `clk_cnt` and `div_r`, and outputs the `sample_stb` and `adv_stb` strobes from a start/clear input.
- The top level holds the FSM, the counters, `shadow` and `par_out`.

## Test plan
- **Loopback, full frame.** Serializer → deser, `DATA_WIDTH`=32, `DATA_DEPTH`=4, `clk_div`=4, `width`=31, `depth`=3, words 0xDEADBEEF, 0x12345678, 0xA5A5A5A5, 0x0000FFFF. Expect a single `valid` at T+512 with `par_out` equal to the input words.
- **Short frame, minimum divider.** `clk_div`=0 and then 1, `width`=7, `depth`=0, byte 0xA5. Expect `par_out[0]`=0x000000A5, words 1–3 = 0, and `valid` at T+8.
- **Abort.** Drop `serial_en` after 10 bits with `clk_div`=3. Expect one `err` pulse, no `valid`, and `par_out` holding the previous frame. The next full frame is received correctly.
- **Reset mid-frame.** Assert `rst` for 1 cycle during word 2. All outputs are 0 immediately. The following frame decodes correctly.
- **Clamp.** `width`=40 and `depth`=7 on 32x4. Expect 32 bits x 4 words and `valid` at T+128·`div_r`.
- **Drain.** Hold `serial_en` high for 5 cycles after the last bit with random `serial_in`. Expect exactly one `valid` and no `err`.
